// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and constants for the instruction/data memory arbiter.
//   mst_id_t                : identifies which core port owns a transaction
//   DEFAULT_MAX_OUTSTANDING : default limit of granted-but-unanswered transfers
//   other_mst()             : returns the opposite master (round-robin helper)
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic {
        MST_INSTR = 1'b0,
        MST_DATA  = 1'b1
    } mst_id_t;

    localparam int DEFAULT_MAX_OUTSTANDING = 2;

    function automatic mst_id_t other_mst(input mst_id_t id);
        return (id == MST_DATA) ? MST_INSTR : MST_DATA;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the core instruction port, core data port and the shared memory port
// seen by the arbiter.
//   slave  : arbiter view (core requests and memory responses are inputs)
//   master : environment view (core + memory drive requests/responses)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;

    // Instruction fetch port
    logic        instr_req_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_addr_i;
    logic [31:0] instr_rdata_o;

    // Load/store port
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;

    // Shared memory port
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_arbiter_id_fifo.sv
// -----------------------------------------------------------------------------
// id_fifo
// In-order FIFO of master IDs for transactions awaiting a memory response.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i, id_i : enqueue id_i at the tail
//   pop_i        : dequeue the head
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
//   head_o       : oldest entry (valid when !empty_o)
// Pointers wrap modulo DEPTH so any depth 1..8 works, not only powers of two.
// -----------------------------------------------------------------------------
module id_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_MAX_OUTSTANDING
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  mst_id_t id_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output mst_id_t head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    mst_id_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        // Push and pop together leave the occupancy unchanged.
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is qualified by the pointers/count, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= id_i;
        end
    end

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Merges a core instruction-fetch port and a load/store port onto one shared
// memory port. Responses return in order and are steered back by an ID FIFO.
//   clk_i : clock, all state changes on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : mem_arbiter_if.slave -- instr_*, data_* core ports and mem_* port
// Parameter MAX_OUTSTANDING (1..8) bounds granted-but-unanswered transfers.
// err_o is a sticky flag raised by a memory response with nothing outstanding.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  bus,
    output logic          err_o
);

    mst_id_t rr_q, rr_d;             // master that wins the next contention
    logic    lock_q, lock_d;         // a request is stalled waiting for mem_gnt_i
    mst_id_t lock_sel_q, lock_sel_d; // master owning the stalled request
    logic    err_q, err_d;

    mst_id_t sel;
    logic    any_req;
    logic    both_req;
    logic    accept;
    logic    fifo_push;
    logic    fifo_pop;
    logic    fifo_full;
    logic    fifo_empty;
    mst_id_t fifo_head;

    assign any_req  = bus.instr_req_i | bus.data_req_i;
    assign both_req = bus.instr_req_i & bus.data_req_i;

    // Selection: a stalled request keeps ownership of the port until granted,
    // otherwise a lone requester wins and contention goes to rr_q.
    always_comb begin
        sel = rr_q;
        if (lock_q && ((lock_sel_q == MST_DATA  && bus.data_req_i) ||
                       (lock_sel_q == MST_INSTR && bus.instr_req_i))) begin
            sel = lock_sel_q;
        end else if (bus.instr_req_i && !bus.data_req_i) begin
            sel = MST_INSTR;
        end else if (bus.data_req_i && !bus.instr_req_i) begin
            sel = MST_DATA;
        end
    end

    // No bypass: a response arriving while full does not free a slot until
    // the following cycle, so the request path never depends on mem_rvalid_i.
    assign bus.mem_req_o   = any_req & ~fifo_full;
    assign accept          = bus.mem_req_o & bus.mem_gnt_i;
    assign fifo_push       = accept;
    assign fifo_pop        = bus.mem_rvalid_i & ~fifo_empty;

    assign bus.mem_we_o    = (sel == MST_DATA) ? bus.data_we_i    : 1'b0;
    assign bus.mem_be_o    = (sel == MST_DATA) ? bus.data_be_i    : 4'hF;
    assign bus.mem_addr_o  = (sel == MST_DATA) ? bus.data_addr_i  : bus.instr_addr_i;
    assign bus.mem_wdata_o = (sel == MST_DATA) ? bus.data_wdata_i : '0;

    assign bus.instr_gnt_o    = ~rst_i & accept & (sel == MST_INSTR);
    assign bus.data_gnt_o     = ~rst_i & accept & (sel == MST_DATA);
    assign bus.instr_rvalid_o = ~rst_i & fifo_pop & (fifo_head == MST_INSTR);
    assign bus.data_rvalid_o  = ~rst_i & fifo_pop & (fifo_head == MST_DATA);
    assign bus.instr_rdata_o  = bus.instr_rvalid_o ? bus.mem_rdata_i : '0;
    assign bus.data_rdata_o   = bus.data_rvalid_o  ? bus.mem_rdata_i : '0;

    always_comb begin
        rr_d       = rr_q;
        lock_d     = bus.mem_req_o & ~bus.mem_gnt_i;
        lock_sel_d = sel;
        err_d      = err_q | (bus.mem_rvalid_i & fifo_empty);
        // Hand priority to the loser only when both actually competed.
        if (accept && both_req) begin
            rr_d = other_mst(sel);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q   <= MST_DATA;
            lock_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            lock_q <= lock_d;
            err_q  <= err_d;
        end
    end

    // Only meaningful while lock_q is set, which reset clears.
    always_ff @(posedge clk_i) begin
        lock_sel_q <= lock_sel_d;
    end

    assign err_o = err_q;

    id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .id_i    (sel),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter with MAX_OUTSTANDING = 2. A vector table
// drives most cycles; short hand-written sequences cover error/reset cases.
// Granted transfers are queued as expected master IDs; each memory response
// pops the queue and checks routing, rdata and the sticky error flag.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam bit I = 1'b0;
    localparam bit D = 1'b1;

    typedef struct {
        bit          ireq;
        bit          dreq;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        bit          gnt;
        bit          rv;
        logic [31:0] rdata;
        bit          exp_req;
        bit          exp_sel;
    } vec_t;

    logic clk;
    logic rst;
    logic err;

    int checks;
    int errors;
    bit exp_err;
    bit sb_q[$];
    vec_t tbl[23];

    mem_arbiter_if bus ();

    mem_arbiter #(
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus),
        .err_o (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, check outputs 1ns later, then
    // update the expected state that the next rising edge commits.
    task automatic apply(input bit r, input bit ireq, input bit dreq,
                         input logic [31:0] iaddr, input logic [31:0] daddr,
                         input bit gnt, input bit rv, input logic [31:0] rdata,
                         input bit exp_req, input bit exp_sel, input string tag);
        bit id;
        @(negedge clk);
        rst              = r;
        bus.instr_req_i  = ireq;
        bus.instr_addr_i = iaddr;
        bus.data_req_i   = dreq;
        bus.data_addr_i  = daddr;
        bus.data_we_i    = 1'b1;
        bus.data_be_i    = 4'hA;
        bus.data_wdata_i = daddr ^ 32'h5A5A_5A5A;
        bus.mem_gnt_i    = gnt;
        bus.mem_rvalid_i = rv;
        bus.mem_rdata_i  = rdata;
        #1;
        chk({tag, " err_o"}, {31'd0, err}, {31'd0, exp_err});
        if (r) begin
            chk({tag, " rst gnts"}, {30'd0, bus.instr_gnt_o, bus.data_gnt_o}, 32'd0);
            chk({tag, " rst rvalids"}, {30'd0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'd0);
            sb_q.delete();
            exp_err = 1'b0;
        end else begin
            chk({tag, " mem_req_o"}, {31'd0, bus.mem_req_o}, {31'd0, exp_req});
            if (exp_req) begin
                chk({tag, " mem_addr_o"}, bus.mem_addr_o, exp_sel ? daddr : iaddr);
                chk({tag, " mem_we_be"}, {27'd0, bus.mem_we_o, bus.mem_be_o},
                    exp_sel ? {27'd0, 1'b1, 4'hA} : {27'd0, 1'b0, 4'hF});
                chk({tag, " mem_wdata_o"}, bus.mem_wdata_o,
                    exp_sel ? (daddr ^ 32'h5A5A_5A5A) : 32'd0);
            end
            chk({tag, " instr_gnt_o"}, {31'd0, bus.instr_gnt_o},
                {31'd0, exp_req & gnt & (exp_sel == I)});
            chk({tag, " data_gnt_o"}, {31'd0, bus.data_gnt_o},
                {31'd0, exp_req & gnt & (exp_sel == D)});
            if (rv && sb_q.size() > 0) begin
                id = sb_q.pop_front();
                chk({tag, " instr_rvalid_o"}, {31'd0, bus.instr_rvalid_o}, {31'd0, id == I});
                chk({tag, " data_rvalid_o"}, {31'd0, bus.data_rvalid_o}, {31'd0, id == D});
                chk({tag, " instr_rdata_o"}, bus.instr_rdata_o, (id == I) ? rdata : 32'd0);
                chk({tag, " data_rdata_o"}, bus.data_rdata_o, (id == D) ? rdata : 32'd0);
            end else begin
                chk({tag, " no rvalid"}, {30'd0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'd0);
                chk({tag, " no rdata"}, bus.instr_rdata_o | bus.data_rdata_o, 32'd0);
                if (rv) exp_err = 1'b1;
            end
            if (exp_req && gnt) sb_q.push_back(exp_sel);
        end
    endtask

    task automatic idle(input string tag);
        apply(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, I, tag);
    endtask

    task automatic stray(input string tag);
        apply(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'hBAD0_0BAD, 1'b0, I, tag);
    endtask

    task automatic do_reset(input string tag);
        apply(1'b1, 1'b1, 1'b1, 32'h10, 32'h20, 1'b1, 1'b1, 32'h0BAD_F00D, 1'b0, I, tag);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_err = 1'b0;
        rst              = 1'b1;
        bus.instr_req_i  = 1'b0;
        bus.instr_addr_i = '0;
        bus.data_req_i   = 1'b0;
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = '0;
        bus.data_addr_i  = '0;
        bus.data_wdata_i = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;

        //          ireq dreq iaddr        daddr        gnt  rv   rdata          req  sel
        tbl[0]  = '{1'b1, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0,         1'b1, D};
        tbl[1]  = '{1'b1, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0,         1'b1, I};
        tbl[2]  = '{1'b1, 1'b1, 32'h104, 32'h204, 1'b1, 1'b0, 32'h0,         1'b0, I};
        tbl[3]  = '{1'b0, 1'b1, 32'h104, 32'h204, 1'b1, 1'b0, 32'h0,         1'b0, I};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h1111_1111, 1'b0, I};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h2222_2222, 1'b0, I};
        tbl[6]  = '{1'b1, 1'b0, 32'h300, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, I};
        tbl[7]  = '{1'b0, 1'b1, 32'h0,   32'h400, 1'b1, 1'b0, 32'h0,         1'b1, D};
        tbl[8]  = '{1'b1, 1'b1, 32'h304, 32'h404, 1'b1, 1'b1, 32'h3333_3333, 1'b0, I};
        tbl[9]  = '{1'b1, 1'b1, 32'h308, 32'h408, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, D};
        tbl[10] = '{1'b1, 1'b1, 32'h30C, 32'h40C, 1'b1, 1'b0, 32'h0,         1'b1, I};
        tbl[11] = '{1'b1, 1'b1, 32'h310, 32'h410, 1'b1, 1'b0, 32'h0,         1'b0, I};
        tbl[12] = '{1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h4444_4444, 1'b0, I};
        tbl[13] = '{1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h5555_5555, 1'b0, I};
        tbl[14] = '{1'b1, 1'b1, 32'h700, 32'h800, 1'b1, 1'b0, 32'h0,         1'b1, D};
        tbl[15] = '{1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h6666_6666, 1'b0, I};
        tbl[16] = '{1'b0, 1'b1, 32'h0,   32'h600, 1'b0, 1'b0, 32'h0,         1'b1, D};
        tbl[17] = '{1'b1, 1'b1, 32'h500, 32'h600, 1'b0, 1'b0, 32'h0,         1'b1, D};
        tbl[18] = '{1'b1, 1'b1, 32'h500, 32'h600, 1'b0, 1'b0, 32'h0,         1'b1, D};
        tbl[19] = '{1'b1, 1'b1, 32'h500, 32'h600, 1'b1, 1'b0, 32'h0,         1'b1, D};
        tbl[20] = '{1'b1, 1'b0, 32'h500, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, I};
        tbl[21] = '{1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h7777_7777, 1'b0, I};
        tbl[22] = '{1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h8888_8888, 1'b0, I};

        // Reset with every input active: no grants or responses may leak out.
        do_reset("reset0");
        do_reset("reset1");

        for (int i = 0; i < 23; i++) begin
            apply(1'b0, tbl[i].ireq, tbl[i].dreq, tbl[i].iaddr, tbl[i].daddr,
                  tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].exp_req, tbl[i].exp_sel,
                  $sformatf("vec%0d", i));
        end

        // Response with nothing outstanding: flagged, routed nowhere, sticky.
        stray("stray0");
        idle("sticky0");
        apply(1'b0, 1'b1, 1'b0, 32'h900, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, I, "after_err_gnt");
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h9999_9999, 1'b0, I, "after_err_rsp");
        idle("sticky1");

        // Reset with one transfer outstanding: its late response is a stray.
        // rr_q is instr-first here, so a contention grant goes to instr.
        apply(1'b0, 1'b1, 1'b1, 32'hA00, 32'hB00, 1'b1, 1'b0, 32'h0, 1'b1, I, "pre_rst_gnt");
        do_reset("mid_rst");
        stray("late_rsp");
        idle("late_sticky");
        do_reset("clr_rst");
        idle("cleared");

        // After reset: data-first priority and an empty FIFO (two more fit).
        apply(1'b0, 1'b1, 1'b1, 32'hC00, 32'hD00, 1'b1, 1'b0, 32'h0, 1'b1, D, "post_rst_d");
        apply(1'b0, 1'b1, 1'b1, 32'hC00, 32'hD00, 1'b1, 1'b0, 32'h0, 1'b1, I, "post_rst_i");
        apply(1'b0, 1'b1, 1'b1, 32'hC04, 32'hD04, 1'b1, 1'b0, 32'h0, 1'b0, I, "post_rst_full");
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0, I, "post_rsp0");
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hAAAA_0002, 1'b0, I, "post_rsp1");
        idle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 2, SHALL set the maximum number of granted-but-unanswered transactions (legal 1..8).
REQ-002 clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset; synchronous and active-high.
REQ-004 instr_req_i  input  1  core fetch request.
REQ-005 instr_gnt_o  output  1  fetch request accepted this cycle.
REQ-006 instr_rvalid_o  output  1  fetch read data valid.
REQ-007 instr_addr_i  input  32  fetch address.
REQ-008 instr_rdata_o  output  32  fetch read data.
REQ-009 data_req_i, data_we_i  input  1 each  core load/store request and write enable.
REQ-010 data_be_i  input  4  byte enables.
REQ-011 data_addr_i, data_wdata_i  input  32 each  load/store address and write data.
REQ-012 data_gnt_o, data_rvalid_o  output  1 each  load/store grant and response valid.
REQ-013 data_rdata_o  output  32  load read data.
REQ-014 mem_req_o, mem_we_o  output  1 each  shared-port request and write enable.
REQ-015 mem_be_o  output  4; mem_addr_o, mem_wdata_o  output  32 each.
REQ-016 mem_gnt_i, mem_rvalid_i  input  1 each; mem_rdata_i  input  32.
REQ-017 err_o  output  1  sticky protocol-error flag.

Function
REQ-018 Arbiter SHALL merge instruction and data ports onto one memory port; every transaction (read or write) SHALL receive exactly one mem_rvalid_i response, in order.
REQ-019 mem_req_o SHALL be combinational: (instr_req_i or data_req_i) and outstanding count < MAX_OUTSTANDING.
REQ-020 Contention: round-robin; rr pointer toggles to the loser after every accepted transfer (mem_req_o and mem_gnt_i) where both requested; single requester always wins.
REQ-021 Selection SHALL hold while mem_req_o is high and mem_gnt_i low (no switch mid-handshake, address/data stable).
REQ-022 Instruction selected: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0, mem_addr_o=instr_addr_i; data selected: all data_* fields passed through.
REQ-023 instr_gnt_o / data_gnt_o SHALL equal mem_gnt_i and mem_req_o and the respective selection; never both high.
REQ-024 On each accepted transfer the master ID SHALL be pushed into an in-order ID FIFO of depth MAX_OUTSTANDING.
REQ-025 On mem_rvalid_i with FIFO non-empty: pop head, assert the matching *_rvalid_o same cycle (zero latency), drive mem_rdata_i on that master's rdata, other rdata 0.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; push when full cannot occur (REQ-019); with count = MAX_OUTSTANDING and rvalid in the same cycle, mem_req_o stays low that cycle (no bypass).
REQ-027 FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-028 mem_rvalid_i with FIFO empty SHALL set err_o (sticky until reset), route to neither master, leave FIFO unchanged.

Reset
REQ-029 rst_i high at a clock edge SHALL empty FIFO, count=0, rr pointer = data-first, err_o=0; gnt/rvalid outputs 0 while rst_i high.
REQ-030 Reset mid-transaction SHALL discard outstanding IDs; later responses to them SHALL set err_o.

Structure
REQ-031 Shared package SHALL hold typedef enum mst_id_t {MST_INSTR, MST_DATA} and MAX_OUTSTANDING default constant.
REQ-032 ID FIFO SHALL be a sub-module id_fifo (parameterised depth, push/pop/full/empty/head).

Verification
REQ-033 Reset, then both req with addr I=0x100, D=0x200, mem_gnt_i=1 -> cycle 1 data granted (mem_addr_o=0x200), cycle 2 instr granted (0x100).
REQ-034 MAX_OUTSTANDING=2, two grants, no rvalid -> mem_req_o=0 on third request until mem_rvalid_i; then instr_rvalid_o/data_rvalid_o in grant order.
REQ-035 Grant and rvalid same cycle at count=1 -> count stays 1, rdata 0xDEADBEEF routed to head master only.
REQ-036 mem_gnt_i held low 3 cycles with data req pending and instr req arriving -> mem_addr_o stays data address until grant.
REQ-037 mem_rvalid_i with empty FIFO -> err_o=1, no *_rvalid_o, err_o cleared only by rst_i.
REQ-038 rst_i pulsed with one outstanding -> count=0, subsequent stray rvalid sets err_o.
